alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter SHW, default 5, width of shift-amount field used (instr[6+SHW-1:6]).
REQ-003 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have valid_in  input  1  request strobe; instr/srca/srcb sampled when valid_in && ready_out.
REQ-006 SHALL have instr  input  32  MIPS instruction word (opcode [31:26], funct [5:0]).
REQ-007 SHALL have srca, srcb  input  WIDTH  operands (srcb = rt or sign-extended immediate, supplied by datapath).
REQ-008 SHALL have ready_out  output  1  high only in IDLE.
REQ-009 SHALL have valid_out  output  1  one-cycle pulse marking result/zero/illegal valid.
REQ-010 SHALL have result  output  WIDTH  registered operation result.
REQ-011 SHALL have zero  output  1  registered (result == 0).
REQ-012 SHALL have illegal  output  1  registered; set with valid_out for undecoded instruction.
REQ-013 SHALL have hi, lo  output  WIDTH  architectural HI/LO registers.
REQ-014 SHALL have alucontrol  output  4  combinational decode of instr (debug/observability).

Function
REQ-015 Decode SHALL be: opcode 0001xx->sub 0110; 001010 slti->0111; 001000 addi, 100011 lw, 101011 sw->add 0010; 001100->and 0000; 001101->or 0001; 001110->xor 0011; opcode-specific entries take priority over funct entries.
REQ-016 Funct decode SHALL be: 100100 and 0000; 100101 or 0001; 100000 add 0010; 100110 xor 0011; 100010 sub 0110; 101010 slt 0111; 100111 nor 1000; 011000 mult 1001; 000000 sll 1010; 000010 srl 1011; 010000 mfhi 1100; 010010 mflo 1101; 011010 div 1110 (REQ-030).
REQ-017 Undecoded instr SHALL give alucontrol 1111, and on accept: illegal=1, result=0, latency 1, hi/lo unchanged.
REQ-018 FSM states SHALL be IDLE, MUL, DIV; accept in IDLE only; valid_in outside IDLE ignored, no queuing.
REQ-019 Single-cycle ops (all but mult/div) SHALL produce valid_out exactly 1 cycle after accept, staying in IDLE (back-to-back accepts every cycle allowed).
REQ-020 add/sub SHALL wrap modulo 2^WIDTH; slt SHALL be signed compare, result 1 or 0; nor = ~(a|b).
REQ-021 sll/srl SHALL shift srcb by shamt; shamt >= WIDTH SHALL give 0; srl is logical.
REQ-022 mfhi/mflo SHALL return current hi/lo.
REQ-023 mult SHALL be signed WIDTHxWIDTH shift-add, one bit per cycle: IDLE->MUL, WIDTH cycles, then {hi,lo} = full 2*WIDTH product, result = lo, valid_out, return to IDLE; accept-to-valid_out latency WIDTH+1.
REQ-024 hi/lo SHALL update only on mult/div completion; intermediate values held in private registers.
REQ-025 valid_out, illegal SHALL be 0 in every cycle except the completion cycle.

Reset
REQ-026 rst SHALL force state IDLE, ready_out=1, valid_out=0, illegal=0, result=0, zero=1, hi=0, lo=0.
REQ-027 rst during MUL/DIV SHALL abort the operation: no valid_out, hi/lo=0.
REQ-028 rst coincident with valid_in SHALL win; request not accepted.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN SHALL compile in the divider and DIV state.
REQ-030 With ALU_SEQ_DIV_EN: div SHALL be signed restoring, WIDTH cycles in DIV, lo=quotient (truncate toward zero), hi=remainder (sign of dividend), result=lo, latency WIDTH+1; srcb=0 SHALL complete in 1 cycle with lo=all ones, hi=srca.
REQ-031 Without ALU_SEQ_DIV_EN: funct 011010 SHALL decode as illegal (REQ-017); no DIV state exists.

Verification
REQ-032 rst high 2 cycles -> ready_out=1, valid_out=0, hi=lo=0, zero=1.
REQ-033 add srca=0xFFFFFFFF srcb=1 -> next cycle valid_out=1, result=0, zero=1; slt srca=0x80000000 srcb=1 back-to-back -> next cycle result=1.
REQ-034 mult srca=-3 srcb=7 -> ready_out low 32 cycles, valid_out at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; mfhi next -> result 0xFFFFFFFF; valid_in during MUL ignored.
REQ-035 With ALU_SEQ_DIV_EN: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 33; div 5/0 -> cycle 1, lo=0xFFFFFFFF, hi=5; without macro div -> illegal=1, result=0.
REQ-036 rst asserted in MUL cycle 10 -> no valid_out, IDLE next cycle, hi=lo=0; instr funct 111111 -> illegal=1, alucontrol=1111.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential MIPS-style ALU with single-cycle ops, a shift-add multiplier
// and an optional restoring divider.
//
// Build option:
//   ALU_SEQ_DIV_EN - compiles in the signed divider and the DIV state. Without it, div
//                    decodes as an illegal instruction.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   valid_in          - request strobe, taken when valid_in && ready_out
//   instr             - instruction word (opcode [31:26], shamt [6+SHW-1:6], funct [5:0])
//   srca, srcb        - operands
//   ready_out         - high only while idle
//   valid_out         - one-cycle pulse qualifying result/zero/illegal
//   result, zero      - registered result and (result == 0)
//   illegal           - registered, pulses with valid_out for an undecoded instruction
//   hi, lo            - architectural HI/LO registers
//   alucontrol        - combinational decode of instr
`timescale 1ns/1ps

module alu_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       alucontrol
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [1:0] StDiv  = 2'd2;
`endif

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpNor  = 4'b1000;
    localparam logic [3:0] OpMult = 4'b1001;
    localparam logic [3:0] OpSll  = 4'b1010;
    localparam logic [3:0] OpSrl  = 4'b1011;
    localparam logic [3:0] OpMfhi = 4'b1100;
    localparam logic [3:0] OpMflo = 4'b1101;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDiv  = 4'b1110;
`endif
    localparam logic [3:0] OpIll  = 4'b1111;

    logic [1:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   alu_res;
    logic [SHW-1:0]     shamt;
    logic               shamt_big;
    logic               unused_instr;

    assign shamt        = instr[6+SHW-1:6];
    assign shamt_big    = {{(32-SHW){1'b0}}, shamt} >= WIDTH;
    assign unused_instr = ^instr[25:6+SHW];

    // Listed opcodes win; anything else falls through to the funct table.
    always_comb begin
        alucontrol = OpIll;
        casez (instr[31:26])
            6'b0001??:                    alucontrol = OpSub;
            6'b001010:                    alucontrol = OpSlt;
            6'b001000, 6'b100011, 6'b101011: alucontrol = OpAdd;
            6'b001100:                    alucontrol = OpAnd;
            6'b001101:                    alucontrol = OpOr;
            6'b001110:                    alucontrol = OpXor;
            default: begin
                case (instr[5:0])
                    6'b100100: alucontrol = OpAnd;
                    6'b100101: alucontrol = OpOr;
                    6'b100000: alucontrol = OpAdd;
                    6'b100110: alucontrol = OpXor;
                    6'b100010: alucontrol = OpSub;
                    6'b101010: alucontrol = OpSlt;
                    6'b100111: alucontrol = OpNor;
                    6'b011000: alucontrol = OpMult;
                    6'b000000: alucontrol = OpSll;
                    6'b000010: alucontrol = OpSrl;
                    6'b010000: alucontrol = OpMfhi;
                    6'b010010: alucontrol = OpMflo;
`ifdef ALU_SEQ_DIV_EN
                    6'b011010: alucontrol = OpDiv;
`endif
                    default:   alucontrol = OpIll;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alucontrol)
            OpAnd:   alu_res = srca & srcb;
            OpOr:    alu_res = srca | srcb;
            OpAdd:   alu_res = srca + srcb;
            OpXor:   alu_res = srca ^ srcb;
            OpSub:   alu_res = srca - srcb;
            OpSlt:   alu_res[0] = $signed(srca) < $signed(srcb);
            OpNor:   alu_res = ~(srca | srcb);
            OpSll:   alu_res = shamt_big ? '0 : srcb << shamt;
            OpSrl:   alu_res = shamt_big ? '0 : srcb >> shamt;
            OpMfhi:  alu_res = hi_q;
            OpMflo:  alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Two's-complement shift-add: the multiplier's sign bit carries weight -2^(WIDTH-1),
    // so the last partial product is subtracted.
    always_comb begin
        acc_nxt = acc_q;
        if (mplier_q[0]) begin
            acc_nxt = (cnt_q == CntLast) ? acc_q - mcand_q : acc_q + mcand_q;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub, rem_nxt, quot_nxt;
    logic             rem_ge;

    // Restoring step on magnitudes; rem < divisor keeps the difference within WIDTH bits.
    assign rem_sh   = {rem_q, quot_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, dvs_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - dvs_q;
    assign rem_nxt  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    assign quot_nxt = {quot_q[WIDTH-2:0], rem_ge};
`endif

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
`ifdef ALU_SEQ_DIV_EN
        quot_d    = quot_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
`endif
        case (state_q)
            StIdle: begin
                if (valid_in) begin
                    case (alucontrol)
                        OpMult: begin
                            state_d  = StMul;
                            mcand_d  = {{WIDTH{srca[WIDTH-1]}}, srca};
                            mplier_d = srcb;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end
`ifdef ALU_SEQ_DIV_EN
                        OpDiv: begin
                            if (srcb == '0) begin
                                valid_d  = 1'b1;
                                lo_d     = '1;
                                hi_d     = srca;
                                result_d = '1;
                                zero_d   = 1'b0;
                            end else begin
                                state_d = StDiv;
                                quot_d  = srca[WIDTH-1] ? -srca : srca;
                                dvs_d   = srcb[WIDTH-1] ? -srcb : srcb;
                                rem_d   = '0;
                                negq_d  = srca[WIDTH-1] ^ srcb[WIDTH-1];
                                negr_d  = srca[WIDTH-1];
                                cnt_d   = '0;
                            end
                        end
`endif
                        OpIll: begin
                            valid_d   = 1'b1;
                            illegal_d = 1'b1;
                            result_d  = '0;
                            zero_d    = 1'b1;
                        end
                        default: begin
                            valid_d  = 1'b1;
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                        end
                    endcase
                end
            end
            StMul: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d  = StIdle;
                    valid_d  = 1'b1;
                    hi_d     = acc_nxt[2*WIDTH-1:WIDTH];
                    lo_d     = acc_nxt[WIDTH-1:0];
                    result_d = acc_nxt[WIDTH-1:0];
                    zero_d   = (acc_nxt[WIDTH-1:0] == '0);
                end
            end
`ifdef ALU_SEQ_DIV_EN
            StDiv: begin
                quot_d = quot_nxt;
                rem_d  = rem_nxt;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d  = StIdle;
                    valid_d  = 1'b1;
                    lo_d     = negq_q ? -quot_nxt : quot_nxt;
                    hi_d     = negr_q ? -rem_nxt : rem_nxt;
                    result_d = negq_q ? -quot_nxt : quot_nxt;
                    zero_d   = (quot_nxt == '0);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
`ifdef ALU_SEQ_DIV_EN
            quot_q    <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
`ifdef ALU_SEQ_DIV_EN
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
`endif
        end
    end

    assign ready_out = (state_q == StIdle);
    assign valid_out = valid_q;
    assign illegal   = illegal_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit (WIDTH=32). The driver issues requests,
// predicts readiness and pushes expected responses; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_alu_seq_unit;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] instr;
    logic [31:0] srca, srcb;
    logic        ready_out, valid_out, zero, illegal;
    logic [31:0] result, hi, lo;
    logic [3:0]  alucontrol;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_at = 0;
    bit   started = 0;
    exp_t exp_q[$];
    exp_t me;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_seq_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .instr      (instr),
        .srca       (srca),
        .srcb       (srcb),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal),
        .hi         (hi),
        .lo         (lo),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'b0, f};
    endfunction

    function automatic logic [3:0] model_ctl(input logic [31:0] ins);
        logic [3:0] c;
        logic [5:0] op;
        op = ins[31:26];
        c  = 4'b1111;
        if (op[5:2] == 4'b0001) c = 4'b0110;
        else if (op == 6'b001010) c = 4'b0111;
        else if (op == 6'b001000 || op == 6'b100011 || op == 6'b101011) c = 4'b0010;
        else if (op == 6'b001100) c = 4'b0000;
        else if (op == 6'b001101) c = 4'b0001;
        else if (op == 6'b001110) c = 4'b0011;
        else begin
            case (ins[5:0])
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100000: c = 4'b0010;
                6'b100110: c = 4'b0011;
                6'b100010: c = 4'b0110;
                6'b101010: c = 4'b0111;
                6'b100111: c = 4'b1000;
                6'b011000: c = 4'b1001;
                6'b000000: c = 4'b1010;
                6'b000010: c = 4'b1011;
                6'b010000: c = 4'b1100;
                6'b010010: c = 4'b1101;
`ifdef ALU_SEQ_DIV_EN
                6'b011010: c = 4'b1110;
`endif
                default:   c = 4'b1111;
            endcase
        end
        return c;
    endfunction

    // Reference behaviour from plain arithmetic; updates the HI/LO model on mult/div.
    task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e, output int lat);
        longint      sa, sb, p, q, r;
        logic [31:0] res;
        logic [4:0]  sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = ins[10:6];
        res = '0;
        lat = 1;
        e.illegal = 1'b0;
        case (model_ctl(ins))
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0011: res = a ^ b;
            4'b0110: res = a - b;
            4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: res = ~(a | b);
            4'b1010: res = b << sh;
            4'b1011: res = b >> sh;
            4'b1100: res = m_hi;
            4'b1101: res = m_lo;
            4'b1001: begin
                p    = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
                res  = m_lo;
                lat  = 33;
            end
            4'b1110: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    lat  = 33;
                end
                res = m_lo;
            end
            default: e.illegal = 1'b1;
        endcase
        e.result = res;
        e.zero   = (res == 0);
        e.hi     = m_hi;
        e.lo     = m_lo;
    endtask

    // One bench cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b);
        logic exp_rdy;
        exp_t e;
        int   lat;
        exp_rdy = (cyc >= ready_at);
        chk("ready_out", ready_out, exp_rdy);
        valid_in = v;
        instr    = ins;
        srca     = a;
        srcb     = b;
        #1;
        chk("alucontrol", alucontrol, model_ctl(ins));
        if (v && exp_rdy) begin
            model(ins, a, b, e, lat);
            e.cyc = cyc + lat;
            exp_q.push_back(e);
            ready_at = cyc + lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc, input logic v, input logic [31:0] ins);
        rst      = 1'b1;
        valid_in = v;
        instr    = ins;
        srca     = 32'd5;
        srcb     = 32'd6;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (ncyc) @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        ready_at = cyc;
        chk("rst_ready", ready_out, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [5:0]  op, f;
        ins = $urandom;
        op  = 6'b000000;
        f   = 6'b100000;
        case ($urandom_range(0, 21))
            0:  f = 6'b100100;
            1:  f = 6'b100101;
            2:  f = 6'b100110;
            3:  f = 6'b100010;
            4:  f = 6'b101010;
            5:  f = 6'b100111;
            6:  f = 6'b011000;
            7:  f = 6'b000000;
            8:  f = 6'b000010;
            9:  f = 6'b010000;
            10: f = 6'b010010;
            11: f = 6'b011010;
            12: f = 6'b111111;
            13: f = 6'b000001;
            14: f = 6'b100000;
            15: op = {4'b0001, 2'($urandom_range(0, 3))};
            16: op = 6'b001010;
            17: op = 6'b001000;
            18: op = 6'b100011;
            19: op = 6'b101011;
            20: op = 6'b001100;
            default: op = ($urandom_range(0, 1) == 0) ? 6'b001101 : 6'b001110;
        endcase
        ins[31:26] = op;
        if (op == 6'b000000) ins[5:0] = f;
        return ins;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid_out=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    me = exp_q.pop_front();
                    chk("result", result, me.result);
                    chk("zero", zero, me.zero);
                    chk("illegal", illegal, me.illegal);
                    chk("hi", hi, me.hi);
                    chk("lo", lo, me.lo);
                    chk("latency_cycle", cyc, me.cyc);
                end
            end else begin
                chk("illegal_idle", illegal, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        do_reset(2, 1'b0, 32'd0);
        started = 1;

        // Wraparound add, then signed slt back-to-back.
        step(1'b1, rtype(6'b100000), 32'hFFFF_FFFF, 32'd1);
        step(1'b1, rtype(6'b101010), 32'h8000_0000, 32'd1);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Signed mult with requests offered (and ignored) while busy, then mfhi/mflo.
        step(1'b1, rtype(6'b011000), 32'hFFFF_FFFD, 32'd7);
        repeat (32) step(1'b1, rtype(6'b100000), $urandom, $urandom);
        step(1'b1, rtype(6'b010000), 32'd0, 32'd0);
        step(1'b1, rtype(6'b010010), 32'd0, 32'd0);

        // Signed div and div-by-zero (illegal when the divider is not built).
        step(1'b1, rtype(6'b011010), 32'hFFFF_FFF9, 32'd2);
        while (cyc < ready_at) step(1'b0, 32'd0, 32'd0, 32'd0);
        step(1'b1, rtype(6'b011010), 32'd5, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Reset in the tenth MUL cycle aborts the multiply.
        step(1'b1, rtype(6'b011000), 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (9) step(1'b0, 32'd0, 32'd0, 32'd0);
        do_reset(1, 1'b0, 32'd0);
        repeat (36) step(1'b0, 32'd0, 32'd0, 32'd0);

        // Reset coincident with a request: nothing is accepted.
        do_reset(1, 1'b1, rtype(6'b100000));
        step(1'b0, 32'd0, 32'd0, 32'd0);

        // Undecoded funct.
        step(1'b1, rtype(6'b111111), 32'd3, 32'd4);
        step(1'b0, 32'd0, 32'd0, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            a = rand_operand();
            b = rand_operand();
            step($urandom_range(0, 3) != 0, rand_instr(), a, b);
        end

        repeat (40) step(1'b0, 32'd0, 32'd0, 32'd0);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
